// File: rtl/gf2_div_if.sv
// gf2_div_if: operand/result bundle for the GF(2)[x] polynomial divider.
// GF2_DIV_REM_ONLY_EN removes the quotient signal (reducer build).
interface gf2_div_if #(
  parameter int DW = 2048,
  parameter int VW = 1024
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic          div_by_zero;
`ifndef GF2_DIV_REM_ONLY_EN
  logic [DW-1:0] quotient;
`endif
  logic [VW-2:0] remainder;

`ifdef GF2_DIV_REM_ONLY_EN
  modport master (
    output start, dividend, divisor,
    input  busy, done, div_by_zero, remainder
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_by_zero, remainder
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );
`endif
endinterface

// File: rtl/gf2_poly_divider.sv
// gf2_poly_divider: bit-serial GF(2)[x] long divider, one quotient bit/cycle.
// GF2_DIV_REM_ONLY_EN: reducer build, remainder only (no quotient, no qsr).
module gf2_poly_divider #(
  parameter int DW = 2048,
  parameter int VW = 1024
) (
  input logic clk,
  input logic rst_n,
  gf2_div_if.slave bus
);
  localparam int CW = $clog2(DW + VW) + 1;

  typedef enum logic [1:0] {IDLE, NORM, DIV, FIN} state_t;

  state_t state, state_nx;

  logic [DW-1:0] a_sr;
  logic [VW-1:0] dsr;
  logic [VW-2:0] r;
  logic [VW-2:0] r_nx;
  logic [VW-1:0] t;
  logic [CW-1:0] s;
  logic [CW-1:0] cnt;
  logic          dz;
  logic          qb;
  logic          accept;
  logic          zero_d;
  logic          last;
  logic          busy_q;
  logic          done_q;
  logic          dz_q;
  logic [VW-2:0] rem_q;
`ifndef GF2_DIV_REM_ONLY_EN
  logic [DW-1:0] qsr;
  logic [DW-1:0] quo_q;
`endif

  assign zero_d = (bus.divisor == '0);
  assign accept = bus.start && !busy_q;
  // next dividend bit enters at the bottom; zeros follow once A is spent
  assign t      = {r, a_sr[DW-1]};
  assign qb     = t[VW-1];
  assign r_nx   = qb ? (t[VW-2:0] ^ dsr[VW-2:0]) : t[VW-2:0];
  assign last   = (cnt == CW'(DW - 1) + s);

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.remainder   = rem_q;
`ifndef GF2_DIV_REM_ONLY_EN
  assign bus.quotient    = quo_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = zero_d ? FIN : NORM;
      NORM: if (dsr[VW-1]) state_nx = DIV;
      DIV:  if (last) state_nx = FIN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      dsr    <= '0;
      r      <= '0;
      s      <= '0;
      cnt    <= '0;
      dz     <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      rem_q  <= '0;
`ifndef GF2_DIV_REM_ONLY_EN
      qsr    <= '0;
      quo_q  <= '0;
`endif
    end else begin
      if (done_q) begin
        done_q <= 1'b0;
        busy_q <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            busy_q <= 1'b1;
            a_sr   <= bus.dividend;
            dsr    <= bus.divisor;
            r      <= '0;
            s      <= '0;
            cnt    <= '0;
            dz     <= zero_d;
`ifndef GF2_DIV_REM_ONLY_EN
            qsr    <= '0;
`endif
          end
        end
        NORM: begin
          if (!dsr[VW-1]) begin
            dsr <= dsr << 1;
            s   <= s + CW'(1);
          end
        end
        DIV: begin
          a_sr <= a_sr << 1;
          r    <= r_nx;
          cnt  <= cnt + CW'(1);
`ifndef GF2_DIV_REM_ONLY_EN
          qsr  <= {qsr[DW-2:0], qb};
`endif
        end
        FIN: begin
          // r, qsr and s were cleared on a zero-divisor accept
          done_q <= 1'b1;
          dz_q   <= dz;
          rem_q  <= r >> s;
`ifndef GF2_DIV_REM_ONLY_EN
          quo_q  <= qsr;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gf2_poly_divider.sv
// tb_gf2_poly_divider: directed and randomised checks, small build DW=8 VW=4.
// Quotient checks drop out when GF2_DIV_REM_ONLY_EN is defined.
module tb_gf2_poly_divider;
  localparam int DW = 8;
  localparam int VW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  gf2_div_if #(.DW(DW), .VW(VW)) bus ();

  gf2_poly_divider #(.DW(DW), .VW(VW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int deg4(input logic [3:0] d);
    int k = -1;
    for (int i = 0; i < 4; i++) if (d[i]) k = i;
    return k;
  endfunction

  function automatic logic [11:0] clmul(input logic [7:0] q,
                                        input logic [3:0] d);
    logic [11:0] p = '0;
    for (int i = 0; i < 8; i++) if (q[i]) p ^= 12'(d) << i;
    return p;
  endfunction

  function automatic logic [2:0] ref_rem(input logic [7:0] a,
                                         input logic [3:0] d);
    logic [7:0] x = a;
    int dd = deg4(d);
    for (int i = 7; i >= dd; i--) if (x[i]) x ^= 8'(d) << (i - dd);
    return x[2:0];
  endfunction

  task automatic op(input logic [7:0] a, input logic [3:0] d,
                    input bit mess, output int lat, output bit busy_ok);
    @(negedge clk);
    for (int k = 0; k < 100 && bus.busy; k++) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = d;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat       = 0;
    busy_ok   = bus.busy;
    for (int e = 1; e <= 100; e++) begin
      if (mess && e == 3) begin
        bus.start    = 1'b1;
        bus.dividend = 8'hFF;
        bus.divisor  = 4'h1;
      end
      if (mess && e == 5) bus.start = 1'b0;
      @(posedge clk); #1;
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic drop_chk(input string tag);
    @(posedge clk); #1;
    chk({tag, "_busy_drop"}, bus.busy, 1'b0);
    chk({tag, "_done_drop"}, bus.done, 1'b0);
  endtask

  task automatic res_chk(input string tag, input logic [7:0] q,
                         input logic [2:0] r, input bit dz);
`ifndef GF2_DIV_REM_ONLY_EN
    chk({tag, "_q"}, bus.quotient, q);
`endif
    chk({tag, "_r"}, bus.remainder, r);
    chk({tag, "_dz"}, bus.div_by_zero, dz);
  endtask

  initial begin
    int lat;
    bit bok;
    int ndone;
    logic [7:0] a;
    logic [3:0] d;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    res_chk("rst", 8'h00, 3'b000, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    op(8'hD6, 4'hB, 1'b0, lat, bok);
    chk("d6b_lat", lat, 10);
    chk("d6b_busy", bok, 1'b1);
    res_chk("d6b", 8'h1E, 3'b100, 1'b0);
    drop_chk("d6b");

    op(8'hD6, 4'h3, 1'b0, lat, bok);
    chk("d63_lat", lat, 14);
    res_chk("d63", 8'h4D, 3'b001, 1'b0);
    drop_chk("d63");

    op(8'hD6, 4'h1, 1'b0, lat, bok);
    chk("d61_lat", lat, 16);
    res_chk("d61", 8'hD6, 3'b000, 1'b0);
    drop_chk("d61");

    op(8'h5A, 4'h0, 1'b0, lat, bok);
    chk("dz_lat", lat, 1);
    chk("dz_busy", bok, 1'b1);
    res_chk("dz", 8'h00, 3'b000, 1'b1);
    drop_chk("dz");

    op(8'h05, 4'hB, 1'b0, lat, bok);
    chk("a05_lat", lat, 10);
    res_chk("a05", 8'h00, 3'b101, 1'b0);
    // start held through the done cycle must not launch a new run
    bus.start    = 1'b1;
    bus.dividend = 8'h33;
    bus.divisor  = 4'h5;
    drop_chk("ign");
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("ign_busy", bus.busy, 1'b0);
    res_chk("ign", 8'h00, 3'b101, 1'b0);

    op(8'hD6, 4'hB, 1'b1, lat, bok);
    chk("mess_lat", lat, 10);
    chk("mess_busy", bok, 1'b1);
    res_chk("mess", 8'h1E, 3'b100, 1'b0);
    drop_chk("mess");

    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'hD6;
    bus.divisor  = 4'h3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    res_chk("arst", 8'h00, 3'b000, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_done", bus.done, 1'b0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("arst_nodone", ndone, 0);

    op(8'hD6, 4'h3, 1'b0, lat, bok);
    chk("post_lat", lat, 14);
    res_chk("post", 8'h4D, 3'b001, 1'b0);

    for (int n = 0; n < 150; n++) begin
      a = 8'($urandom);
      d = 4'($urandom_range(1, 15));
      op(a, d, 1'b0, lat, bok);
      chk($sformatf("rnd%0d_lat", n), lat, 2 * (3 - deg4(d)) + 10);
      chk($sformatf("rnd%0d_r", n), bus.remainder, ref_rem(a, d));
`ifndef GF2_DIV_REM_ONLY_EN
      chk($sformatf("rnd%0d_qdr", n),
          clmul(bus.quotient, d) ^ 12'(bus.remainder), 12'(a));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
